decode_ctrl: RTL and testbench

DECODE_CTRL -- requirements
Module: decode_ctrl

---
 rtl/decode_ctrl.sv | 278 +++++++++++++++++++++++++++
 tb/tb_decode_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl.sv
// Decode stage controller: one-entry instruction register, instruction decode,
// operand-forward selection, load-use stall and multiply-wait sequencing.
module decode_ctrl #(
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned MD_CYCLES  = 4,
    parameter int unsigned SRC_W      = $clog2(FWD_STAGES + 2)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    if_valid,
    input  logic [31:0]             if_pc,
    input  logic [31:0]             if_instr,
    output logic                    id_ready,
    input  logic                    ex_ready,
    input  logic [FWD_STAGES-1:0]   fwd_wr_en,
    input  logic [5*FWD_STAGES-1:0] fwd_wr_addr,
    input  logic [FWD_STAGES-1:0]   fwd_is_load,
    output logic                    id_valid,
    output logic [31:0]             id_pc,
    output logic                    reg_rd_en1,
    output logic                    reg_rd_en2,
    output logic                    reg_wr_en,
    output logic [4:0]              reg_wr_addr,
    output logic [3:0]              alu_op,
    output logic [SRC_W-1:0]        alu_src1,
    output logic [SRC_W-1:0]        alu_src2,
    output logic [31:0]             imm,
    output logic                    id_illegal
);

    localparam int unsigned CNT_W = $clog2(MD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MD_CYCLES - 1);

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_MUL  = 6'h02;

    localparam logic [3:0] ALU_ADDU = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_MUL  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_ADD  = 4'd11;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MD_WAIT  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic [31:0]      instr_q, pc_q;

    logic [5:0]  opc, fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm16;
    logic        dec_ill, dec_wr, dec_rd1, dec_rd2, dec_mul;
    logic [4:0]  dec_wa;
    logic [3:0]  dec_op;
    logic [31:0] dec_imm;
    logic        ld_haz, valid_c, xfer, fill;
    logic        fwd_load_unused;

    assign opc   = instr_q[31:26];
    assign rs    = instr_q[25:21];
    assign rt    = instr_q[20:16];
    assign rd    = instr_q[15:11];
    assign sh    = instr_q[10:6];
    assign fn    = instr_q[5:0];
    assign imm16 = instr_q[15:0];

    // Only the EX stage can hold a result that is not yet available.
    assign fwd_load_unused = ^fwd_is_load;

    // Lowest-numbered matching stage wins; $0 and unread sources never forward.
    function automatic logic [SRC_W-1:0] fwd_sel(input logic en, input logic [4:0] addr);
        logic [SRC_W-1:0] sel;
        sel = en ? SRC_W'(1) : SRC_W'(0);
        for (int k = int'(FWD_STAGES) - 1; k >= 0; k--) begin
            if (en && (addr != 5'd0) && fwd_wr_en[k] && (fwd_wr_addr[5*k +: 5] == addr)) begin
                sel = SRC_W'(k + 2);
            end
        end
        return sel;
    endfunction

    // Instruction decode of the held word.
    always_comb begin
        dec_ill = 1'b0;
        dec_wr  = 1'b0;
        dec_wa  = 5'd0;
        dec_op  = ALU_ADDU;
        dec_rd1 = 1'b0;
        dec_rd2 = 1'b0;
        dec_imm = 32'd0;
        dec_mul = 1'b0;
        case (opc)
            OP_SPECIAL: begin
                dec_wr  = 1'b1;
                dec_wa  = rd;
                dec_rd1 = 1'b1;
                dec_rd2 = 1'b1;
                case (fn)
                    FN_SLL:  begin dec_op = ALU_SLL; dec_rd1 = 1'b0; dec_imm = {27'd0, sh}; end
                    FN_SRL:  begin dec_op = ALU_SRL; dec_rd1 = 1'b0; dec_imm = {27'd0, sh}; end
                    FN_SRA:  begin dec_op = ALU_SRA; dec_rd1 = 1'b0; dec_imm = {27'd0, sh}; end
                    FN_SLLV: dec_op = ALU_SLL;
                    FN_SRLV: dec_op = ALU_SRL;
                    FN_SRAV: dec_op = ALU_SRA;
                    FN_ADD:  dec_op = ALU_ADD;
                    FN_ADDU: dec_op = ALU_ADDU;
                    FN_SUB, FN_SUBU: dec_op = ALU_SUB;
                    FN_AND:  dec_op = ALU_AND;
                    FN_OR:   dec_op = ALU_OR;
                    FN_XOR:  dec_op = ALU_XOR;
                    FN_NOR:  dec_op = ALU_NOR;
                    FN_SLT:  dec_op = ALU_SLT;
                    default: dec_ill = 1'b1;
                endcase
            end
            OP_SPECIAL2: begin
                dec_wr  = 1'b1;
                dec_wa  = rd;
                dec_rd1 = 1'b1;
                dec_rd2 = 1'b1;
                dec_op  = ALU_MUL;
                dec_mul = 1'b1;
                if (fn != FN_MUL) dec_ill = 1'b1;
            end
            OP_ADDI, OP_ADDIU: begin
                dec_wr  = 1'b1;
                dec_wa  = rt;
                dec_rd1 = 1'b1;
                dec_op  = (opc == OP_ADDI) ? ALU_ADD : ALU_ADDU;
                dec_imm = {{16{imm16[15]}}, imm16};
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec_wr  = 1'b1;
                dec_wa  = rt;
                dec_rd1 = 1'b1;
                dec_op  = (opc == OP_ANDI) ? ALU_AND : ((opc == OP_ORI) ? ALU_OR : ALU_XOR);
                dec_imm = {16'd0, imm16};
            end
            OP_LUI: begin
                // rs is architecturally $0, so OR with it yields the upper immediate.
                dec_wr  = 1'b1;
                dec_wa  = rt;
                dec_rd1 = 1'b1;
                dec_op  = ALU_OR;
                dec_imm = {imm16, 16'd0};
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            dec_wr  = 1'b0;
            dec_wa  = 5'd0;
            dec_op  = ALU_ADDU;
            dec_rd1 = 1'b0;
            dec_rd2 = 1'b0;
            dec_imm = 32'd0;
            dec_mul = 1'b0;
        end
    end

    assign ld_haz = full_q && fwd_is_load[0] && fwd_wr_en[0] && (fwd_wr_addr[4:0] != 5'd0)
                  && ((dec_rd1 && (rs == fwd_wr_addr[4:0])) || (dec_rd2 && (rt == fwd_wr_addr[4:0])));
    // The hazard cycle itself is the bubble; LD_STALL presents once the load has reached MEM.
    assign valid_c  = full_q && (state_q != MD_WAIT) && !ld_haz;
    assign xfer     = valid_c && ex_ready;
    assign id_ready = rstn && (!full_q || xfer);
    assign fill     = if_valid && id_ready;
    assign id_valid = valid_c;
    assign full_d   = fill ? 1'b1 : (xfer ? 1'b0 : full_q);

    // Next-state logic for stall sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (ld_haz) begin
                    state_d = LD_STALL;
                end else if (xfer && dec_mul) begin
                    state_d = MD_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            LD_STALL: begin
                if (xfer && dec_mul) begin
                    state_d = MD_WAIT;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d = RUN;
                end
            end
            MD_WAIT: begin
                if (cnt_q != CNT_W'(0)) cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RUN;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            instr_q <= 32'd0;
            pc_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            if (fill) begin
                instr_q <= if_instr;
                pc_q    <= if_pc;
            end
        end
    end

    // Control outputs are quiet whenever nothing is held.
    always_comb begin
        id_pc       = 32'd0;
        reg_rd_en1  = 1'b0;
        reg_rd_en2  = 1'b0;
        reg_wr_en   = 1'b0;
        reg_wr_addr = 5'd0;
        alu_op      = 4'd0;
        alu_src1    = '0;
        alu_src2    = '0;
        imm         = 32'd0;
        id_illegal  = 1'b0;
        if (full_q) begin
            id_pc       = pc_q;
            reg_rd_en1  = dec_rd1;
            reg_rd_en2  = dec_rd2;
            reg_wr_en   = dec_wr;
            reg_wr_addr = dec_wa;
            alu_op      = dec_op;
            alu_src1    = fwd_sel(dec_rd1, rs);
            alu_src2    = fwd_sel(dec_rd2, rt);
            imm         = dec_imm;
            id_illegal  = dec_ill;
        end
    end

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed bench for decode_ctrl: expected decodes queued on offer, checked on transfer.
module tb_decode_ctrl;

    localparam int unsigned SRC_W = 2;

    typedef struct packed {
        logic [31:0]      pc;
        logic             ill;
        logic             wr;
        logic [4:0]       wa;
        logic [3:0]       op;
        logic             rd1;
        logic             rd2;
        logic [SRC_W-1:0] s1;
        logic [SRC_W-1:0] s2;
        logic [31:0]      imm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_valid;
    logic [31:0] if_pc, if_instr;
    logic        id_ready, ex_ready;
    logic [1:0]  fwd_wr_en, fwd_is_load;
    logic [9:0]  fwd_wr_addr;
    logic        id_valid;
    logic [31:0] id_pc, imm;
    logic        reg_rd_en1, reg_rd_en2, reg_wr_en, id_illegal;
    logic [4:0]  reg_wr_addr;
    logic [3:0]  alu_op;
    logic [SRC_W-1:0] alu_src1, alu_src2;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    decode_ctrl dut (
        .clk(clk), .rstn(rstn),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .id_ready(id_ready),
        .ex_ready(ex_ready),
        .fwd_wr_en(fwd_wr_en), .fwd_wr_addr(fwd_wr_addr), .fwd_is_load(fwd_is_load),
        .id_valid(id_valid), .id_pc(id_pc),
        .reg_rd_en1(reg_rd_en1), .reg_rd_en2(reg_rd_en2),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
        .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .imm(imm), .id_illegal(id_illegal)
    );

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic logic [31:0] mul(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
        return {6'h1C, rs, rt, rd, 5'd0, 6'h02};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic ill, input logic wr,
                        input logic [4:0] wa, input logic [3:0] op, input logic rd1,
                        input logic rd2, input logic [SRC_W-1:0] s1,
                        input logic [SRC_W-1:0] s2, input logic [31:0] im);
        exp_t e;
        e = '{pc: pc, ill: ill, wr: wr, wa: wa, op: op, rd1: rd1, rd2: rd2,
              s1: s1, s2: s2, imm: im};
        sb.push_back(e);
    endtask

    // Falling-edge sample; a transfer pops and compares the oldest expectation.
    task automatic at_neg();
        exp_t e, o;
        @(negedge clk);
        if (id_valid && ex_ready) begin
            vectors++;
            assert (sb.size() > 0) else begin
                miscompares++;
                $error("FAIL sb_underflow: observed transfer pc %h expected none", id_pc);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                o = '{pc: id_pc, ill: id_illegal, wr: reg_wr_en, wa: reg_wr_addr, op: alu_op,
                      rd1: reg_rd_en1, rd2: reg_rd_en2, s1: alu_src1, s2: alu_src2, imm: imm};
                vectors++;
                assert (o === e) else begin
                    miscompares++;
                    $error("FAIL sb_out pc %h: observed %h expected %h", e.pc, o, e);
                end
            end
        end
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        at_neg();
        to_pos();
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] instr);
        if_valid = 1'b1;
        if_pc    = pc;
        if_instr = instr;
    endtask

    task automatic set_fwd(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                           input logic [1:0] ld);
        fwd_wr_en   = en;
        fwd_wr_addr = {a1, a0};
        fwd_is_load = ld;
    endtask

    initial begin
        rstn = 1'b0;
        if_valid = 1'b0;
        if_pc = 32'd0;
        if_instr = 32'd0;
        ex_ready = 1'b1;
        set_fwd(2'b00, 5'd0, 5'd0, 2'b00);

        at_neg();
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_ready", 32'(id_ready), 32'd0);
        chk("rst_pc", id_pc, 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_wr_en", 32'(reg_wr_en), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_illegal", 32'(id_illegal), 32'd0);
        to_pos();
        rstn = 1'b1;
        at_neg();
        chk("ready_after_reset", 32'(id_ready), 32'd1);
        chk("empty_valid", 32'(id_valid), 32'd0);
        to_pos();

        // ORI $2,$1,0x8001
        offer(32'h100, itype(6'h0D, 5'd1, 5'd2, 16'h8001));
        push(32'h100, 0, 1, 5'd2, 4'd2, 1, 0, 2'd1, 2'd0, 32'h0000_8001);
        tick();
        if_valid = 1'b0;
        at_neg();
        chk("ori_valid", 32'(id_valid), 32'd1);
        to_pos();

        // ADDU with dual forward, then ADDU reading $0 while $0 is written
        offer(32'h104, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21));
        push(32'h104, 0, 1, 5'd3, 4'd0, 1, 1, 2'd2, 2'd1, 32'd0);
        tick();
        set_fwd(2'b11, 5'd1, 5'd1, 2'b00);
        offer(32'h108, rtype(5'd0, 5'd2, 5'd3, 5'd0, 6'h21));
        push(32'h108, 0, 1, 5'd3, 4'd0, 1, 1, 2'd1, 2'd3, 32'd0);
        at_neg();
        chk("zero_bubble_ready", 32'(id_ready), 32'd1);
        to_pos();
        set_fwd(2'b11, 5'd0, 5'd2, 2'b00);
        if_valid = 1'b0;
        tick();
        set_fwd(2'b00, 5'd0, 5'd0, 2'b00);

        // Back-to-back stream: shifts, immediates, illegal words
        offer(32'h10C, rtype(5'd0, 5'd5, 5'd4, 5'd7, 6'h00));
        push(32'h10C, 0, 1, 5'd4, 4'd8, 0, 1, 2'd0, 2'd1, 32'd7);
        tick();
        offer(32'h110, rtype(5'd0, 5'd7, 5'd6, 5'd31, 6'h03));
        push(32'h110, 0, 1, 5'd6, 4'd10, 0, 1, 2'd0, 2'd1, 32'd31);
        tick();
        offer(32'h114, rtype(5'd9, 5'd10, 5'd8, 5'd0, 6'h06));
        push(32'h114, 0, 1, 5'd8, 4'd9, 1, 1, 2'd1, 2'd1, 32'd0);
        tick();
        offer(32'h118, itype(6'h0F, 5'd0, 5'd11, 16'h1234));
        push(32'h118, 0, 1, 5'd11, 4'd2, 1, 0, 2'd1, 2'd0, 32'h1234_0000);
        tick();
        offer(32'h11C, itype(6'h08, 5'd1, 5'd12, 16'hFFFE));
        push(32'h11C, 0, 1, 5'd12, 4'd11, 1, 0, 2'd1, 2'd0, 32'hFFFF_FFFE);
        tick();
        offer(32'h120, itype(6'h0C, 5'd1, 5'd13, 16'h80F0));
        push(32'h120, 0, 1, 5'd13, 4'd3, 1, 0, 2'd1, 2'd0, 32'h0000_80F0);
        tick();
        offer(32'h124, itype(6'h09, 5'd1, 5'd14, 16'h8000));
        push(32'h124, 0, 1, 5'd14, 4'd0, 1, 0, 2'd1, 2'd0, 32'hFFFF_8000);
        tick();
        offer(32'h128, itype(6'h0E, 5'd1, 5'd15, 16'hFFFF));
        push(32'h128, 0, 1, 5'd15, 4'd6, 1, 0, 2'd1, 2'd0, 32'h0000_FFFF);
        tick();
        offer(32'h12C, 32'hFC00_0000);
        push(32'h12C, 1, 0, 5'd0, 4'd0, 0, 0, 2'd0, 2'd0, 32'd0);
        tick();
        offer(32'h130, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h01));
        push(32'h130, 1, 0, 5'd0, 4'd0, 0, 0, 2'd0, 2'd0, 32'd0);
        tick();
        offer(32'h134, rtype(5'd1, 5'd2, 5'd16, 5'd0, 6'h2A));
        push(32'h134, 0, 1, 5'd16, 4'd5, 1, 1, 2'd1, 2'd1, 32'd0);
        tick();
        if_valid = 1'b0;
        tick();

        // Execute back-pressure holds the instruction
        offer(32'h138, rtype(5'd1, 5'd2, 5'd17, 5'd0, 6'h27));
        push(32'h138, 0, 1, 5'd17, 4'd7, 1, 1, 2'd1, 2'd1, 32'd0);
        tick();
        if_valid = 1'b0;
        ex_ready = 1'b0;
        at_neg();
        chk("hold_valid", 32'(id_valid), 32'd1);
        chk("hold_ready", 32'(id_ready), 32'd0);
        to_pos();
        ex_ready = 1'b1;
        tick();

        // Load-use: one bubble, then forward from MEM
        offer(32'h200, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21));
        push(32'h200, 0, 1, 5'd3, 4'd0, 1, 1, 2'd3, 2'd1, 32'd0);
        tick();
        if_valid = 1'b0;
        set_fwd(2'b01, 5'd1, 5'd0, 2'b01);
        at_neg();
        chk("lduse_valid", 32'(id_valid), 32'd0);
        chk("lduse_ready", 32'(id_ready), 32'd0);
        to_pos();
        set_fwd(2'b10, 5'd0, 5'd1, 2'b00);
        tick();
        set_fwd(2'b00, 5'd0, 5'd0, 2'b00);

        // MUL blocked by load stall, then transfers into the multiply wait
        offer(32'h300, mul(5'd1, 5'd2, 5'd5));
        push(32'h300, 0, 1, 5'd5, 4'd4, 1, 1, 2'd3, 2'd1, 32'd0);
        tick();
        offer(32'h304, itype(6'h0D, 5'd0, 5'd7, 16'h0055));
        set_fwd(2'b01, 5'd1, 5'd0, 2'b01);
        at_neg();
        chk("mul_ld_prio_valid", 32'(id_valid), 32'd0);
        chk("mul_ld_prio_ready", 32'(id_ready), 32'd0);
        to_pos();
        set_fwd(2'b10, 5'd0, 5'd1, 2'b00);
        push(32'h304, 0, 1, 5'd7, 4'd2, 1, 0, 2'd1, 2'd0, 32'h0000_0055);
        at_neg();
        chk("mul_fill_ready", 32'(id_ready), 32'd1);
        to_pos();
        set_fwd(2'b00, 5'd0, 5'd0, 2'b00);
        if_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("md_wait_valid", 32'(id_valid), 32'd0);
            to_pos();
        end
        at_neg();
        chk("md_done_valid", 32'(id_valid), 32'd1);
        to_pos();

        // Reset during multiply wait discards the held instruction
        offer(32'h400, mul(5'd3, 5'd4, 5'd5));
        push(32'h400, 0, 1, 5'd5, 4'd4, 1, 1, 2'd1, 2'd1, 32'd0);
        tick();
        offer(32'h404, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21));
        tick();
        if_valid = 1'b0;
        tick();
        rstn = 1'b0;
        at_neg();
        chk("mdrst_valid", 32'(id_valid), 32'd0);
        chk("mdrst_ready", 32'(id_ready), 32'd0);
        chk("mdrst_pc", id_pc, 32'd0);
        chk("mdrst_wr_en", 32'(reg_wr_en), 32'd0);
        chk("mdrst_rd_en1", 32'(reg_rd_en1), 32'd0);
        chk("mdrst_src1", 32'(alu_src1), 32'd0);
        to_pos();
        rstn = 1'b1;
        at_neg();
        chk("mdrst_release_ready", 32'(id_ready), 32'd1);
        to_pos();
        for (int i = 0; i < 6; i++) begin
            at_neg();
            chk("mdrst_discarded", 32'(id_valid), 32'd0);
            to_pos();
        end

        offer(32'h500, itype(6'h0D, 5'd1, 5'd2, 16'h8001));
        push(32'h500, 0, 1, 5'd2, 4'd2, 1, 0, 2'd1, 2'd0, 32'h0000_8001);
        tick();
        if_valid = 1'b0;
        tick();
        tick();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
